// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier (RNE), stages S1 unpack, S2 product, S3 normalise, then round/pack into the output register.
// Latency 3 cycles after accept; the whole pipe freezes while out_valid && !out_ready. FP_MUL_SUBNORM_EN = gradual underflow, else flush-to-zero.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2*MAN_W + 2;
  localparam int BIAS = (1 << (EXP_W-1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {K_NUM, K_NAN, K_INF, K_ZERO} kind_e;

  typedef struct packed {
    logic             nan;
    logic             snan;
    logic             inf;
    logic             zero;
    logic [EXP_W-1:0] ex;
    logic [MAN_W:0]   sig;
  } op_t;

  function automatic op_t unpack(input logic [W-1:0] x);
    op_t o;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[W-2:MAN_W];
    f = x[MAN_W-1:0];
    o.nan  = (&e) && (|f);
    o.snan = o.nan && !f[MAN_W-1];
    o.inf  = (&e) && !(|f);
`ifdef FP_MUL_SUBNORM_EN
    o.zero = !(|e) && !(|f);
    o.ex   = (|e) ? e : EXP_W'(1);
    o.sig  = {|e, f};
`else
    o.zero = !(|e);
    o.ex   = e;
    o.sig  = {1'b1, f};
`endif
    return o;
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  op_t   ua, ub;
  kind_e s1_kind_d;
  logic  s1_inv_d;

  always_comb begin
    ua = unpack(a);
    ub = unpack(b);
    s1_kind_d = K_NUM;
    s1_inv_d  = 1'b0;
    if (ua.nan || ub.nan || (ua.inf && ub.zero) || (ua.zero && ub.inf)) begin
      s1_kind_d = K_NAN;
      s1_inv_d  = ua.snan || ub.snan || (ua.inf && ub.zero) || (ua.zero && ub.inf);
    end else if (ua.inf || ub.inf) begin
      s1_kind_d = K_INF;
    end else if (ua.zero || ub.zero) begin
      s1_kind_d = K_ZERO;
    end
  end

  logic                  s1_vld, s2_vld, s3_vld;
  logic                  s1_sign, s2_sign, s3_sign;
  kind_e                 s1_kind, s2_kind, s3_kind;
  logic                  s1_inv, s2_inv, s3_inv;
  logic signed [EW2-1:0] s1_exp, s2_exp, s3_exp;
  logic [MAN_W:0]        s1_ma, s1_mb;
  logic [PW-1:0]         s2_prod, s3_q;
  logic                  s3_sticky, s3_tiny;

  logic signed [EW2-1:0] s3_exp_d;
  logic [PW-1:0]         s3_q_d;
  logic                  s3_sticky_d, s3_tiny_d;

  // s3_q holds the significand with its unit bit at PW-1; s3_exp is the matching biased exponent.
`ifdef FP_MUL_SUBNORM_EN
  always_comb begin
    int ex, lz, sh;
    logic [2*PW-1:0] wide;
    ex   = int'(s2_exp) + 1;
    lz   = PW;
    sh   = 0;
    wide = '0;
    for (int i = 0; i < PW; i++) if (s2_prod[i]) lz = PW - 1 - i;
    s3_sticky_d = 1'b0;
    if (ex < 1) begin
      sh          = (1 - ex > PW + 1) ? PW + 1 : 1 - ex;
      wide        = {s2_prod, {PW{1'b0}}} >> sh;
      s3_q_d      = wide[2*PW-1:PW];
      s3_sticky_d = |wide[PW-1:0];
      ex          = 1;
    end else begin
      // Left-normalise, but never below the minimum normal exponent.
      sh     = (lz < ex - 1) ? lz : ex - 1;
      s3_q_d = s2_prod << sh;
      ex     = ex - sh;
    end
    s3_exp_d  = EW2'(ex);
    s3_tiny_d = !s3_q_d[PW-1];
  end
`else
  always_comb begin
    int ex;
    ex     = int'(s2_exp) + 1;
    s3_q_d = s2_prod;
    if (!s2_prod[PW-1]) begin
      s3_q_d = s2_prod << 1;
      ex     = ex - 1;
    end
    s3_sticky_d = 1'b0;
    s3_exp_d    = EW2'(ex);
    s3_tiny_d   = (ex < 1);
  end
`endif

  logic [MAN_W:0]   mant, mant_f;
  logic [MAN_W+1:0] mant_r;
  logic             rnd, stk, up, inexact;
  logic [W-1:0]     res_d;
  logic [3:0]       flags_d;

  always_comb begin
    int ex_f;
    mant    = s3_q[PW-1 -: MAN_W+1];
    rnd     = s3_q[MAN_W];
    stk     = (|s3_q[MAN_W-1:0]) || s3_sticky;
    inexact = rnd || stk;
    up      = rnd && (stk || mant[0]);
    mant_r  = {1'b0, mant} + (MAN_W+2)'(up);
    ex_f    = int'(s3_exp);
    mant_f  = mant_r[MAN_W:0];
    if (mant_r[MAN_W+1]) begin
      mant_f = mant_r[MAN_W+1:1];
      ex_f   = ex_f + 1;
    end
    res_d   = {s3_sign, (mant_f[MAN_W] ? EXP_W'(ex_f) : EXP_W'(0)), mant_f[MAN_W-1:0]};
    flags_d = {3'b000, inexact};
    if (ex_f >= EMAX) begin
      res_d   = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end
`ifdef FP_MUL_SUBNORM_EN
    else if (s3_tiny && inexact) begin
      flags_d[1] = 1'b1;
    end
`else
    else if (s3_tiny) begin
      res_d   = {s3_sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
`endif
    case (s3_kind)
      K_NAN: begin
        res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d = {s3_inv, 3'b000};
      end
      K_INF: begin
        res_d   = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d = 4'b0000;
      end
      K_ZERO: begin
        res_d   = {s3_sign, {(W-1){1'b0}}};
        flags_d = 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0; s1_sign <= 1'b0; s1_kind <= K_NUM; s1_inv <= 1'b0;
      s1_exp <= '0;   s1_ma   <= '0;   s1_mb   <= '0;
      s2_vld <= 1'b0; s2_sign <= 1'b0; s2_kind <= K_NUM; s2_inv <= 1'b0;
      s2_exp <= '0;   s2_prod <= '0;
      s3_vld <= 1'b0; s3_sign <= 1'b0; s3_kind <= K_NUM; s3_inv <= 1'b0;
      s3_exp <= '0;   s3_q    <= '0;   s3_sticky <= 1'b0; s3_tiny <= 1'b0;
      out_valid <= 1'b0; result <= '0; flags <= '0;
    end else if (advance) begin
      s1_vld  <= in_valid;
      s1_sign <= a[W-1] ^ b[W-1];
      s1_kind <= s1_kind_d;
      s1_inv  <= s1_inv_d;
      s1_exp  <= EW2'(ua.ex) + EW2'(ub.ex) - EW2'(BIAS);
      s1_ma   <= ua.sig;
      s1_mb   <= ub.sig;

      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_kind <= s1_kind;
      s2_inv  <= s1_inv;
      s2_exp  <= s1_exp;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);

      s3_vld    <= s2_vld;
      s3_sign   <= s2_sign;
      s3_kind   <= s2_kind;
      s3_inv    <= s2_inv;
      s3_exp    <= s3_exp_d;
      s3_q      <= s3_q_d;
      s3_sticky <= s3_sticky_d;
      s3_tiny   <= s3_tiny_d;

      out_valid <= s3_vld;
      result    <= res_d;
      flags     <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe in its FP32 default configuration.
module tb_fp_mul_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Issues one operation into an empty pipe and waits (bounded) for its result.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = result;
    f = flags;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result); else passed++;
    total++; if (flags !== 4'h0) $display("FAIL reset_flags got %h want 0", flags); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [3:0] f; int lat;
    run_op(32'h3F800000, 32'h40000000, r, f, lat);
    total++; if (r !== 32'h40000000) $display("FAIL basic_result got %h want 40000000", r); else passed++;
    total++; if (f !== 4'h0) $display("FAIL basic_flags got %h want 0", f); else passed++;
    total++; if (lat !== 3) $display("FAIL basic_latency got %0d want 3", lat); else passed++;
  endtask

  task automatic test_specials();
    vec_t tv [8];
    logic [31:0] r; logic [3:0] f; int lat;
    tv[0] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8};
    tv[1] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0};
    tv[2] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8};
    tv[3] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'h0};
    tv[4] = '{32'h80000000, 32'h40400000, 32'h80000000, 4'h0};
    tv[5] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5};
    tv[6] = '{32'hFF000000, 32'h40000000, 32'hFF800000, 4'h5};
    tv[7] = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'h8};
    for (int i = 0; i < 8; i++) begin
      run_op(tv[i].a, tv[i].b, r, f, lat);
      total++; if (r !== tv[i].r) $display("FAIL special[%0d]_result got %h want %h", i, r, tv[i].r); else passed++;
      total++; if (f !== tv[i].f) $display("FAIL special[%0d]_flags got %h want %h", i, f, tv[i].f); else passed++;
    end
  endtask

  task automatic test_rounding();
    vec_t tv [6];
    logic [31:0] r; logic [3:0] f; int lat;
    tv[0] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1};
    tv[1] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1};
    tv[2] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1};
    tv[3] = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'h1};
    tv[4] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0};
    tv[5] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0};
    for (int i = 0; i < 6; i++) begin
      run_op(tv[i].a, tv[i].b, r, f, lat);
      total++; if (r !== tv[i].r) $display("FAIL round[%0d]_result got %h want %h", i, r, tv[i].r); else passed++;
      total++; if (f !== tv[i].f) $display("FAIL round[%0d]_flags got %h want %h", i, f, tv[i].f); else passed++;
    end
  endtask

  task automatic test_underflow();
    vec_t tv [5];
    logic [31:0] r; logic [3:0] f; int lat;
`ifdef FP_MUL_SUBNORM_EN
    tv[0] = '{32'h00400000, 32'h40000000, 32'h00800000, 4'h0};
    tv[2] = '{32'h00800000, 32'h3F000000, 32'h00400000, 4'h0};
    tv[4] = '{32'h80800000, 32'h3E800000, 32'h80200000, 4'h0};
`else
    tv[0] = '{32'h00400000, 32'h40000000, 32'h00000000, 4'h0};
    tv[2] = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'h3};
    tv[4] = '{32'h80800000, 32'h3E800000, 32'h80000000, 4'h3};
`endif
    tv[1] = '{32'h00800000, 32'h00800000, 32'h00000000, 4'h3};
    tv[3] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'h0};
    for (int i = 0; i < 5; i++) begin
      run_op(tv[i].a, tv[i].b, r, f, lat);
      total++; if (r !== tv[i].r) $display("FAIL under[%0d]_result got %h want %h", i, r, tv[i].r); else passed++;
      total++; if (f !== tv[i].f) $display("FAIL under[%0d]_flags got %h want %h", i, f, tv[i].f); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8];
    logic [31:0] exp_r [8];
    logic [31:0] held;
    logic        hold_pending, acc;
    int sent, got, cyc, extra;
    va    = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    exp_r = '{32'h40400000, 32'h40C00000, 32'h41100000, 32'h41400000,
              32'h41700000, 32'h41900000, 32'h41A80000, 32'h41C00000};
    sent = 0; got = 0; cyc = 0; hold_pending = 1'b0; held = '0;
    @(negedge clk);
    while (got < 8 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 8);
      if (sent < 8) a = va[sent];
      b = 32'h40400000;
      #1;
      total++; if (in_ready !== (!out_valid || out_ready))
        $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, in_ready, !out_valid || out_ready); else passed++;
      if (hold_pending) begin
        total++; if (out_valid !== 1'b1 || result !== held)
          $display("FAIL b2b_stall_hold cyc %0d got %b/%h want 1/%h", cyc, out_valid, result, held); else passed++;
      end
      if (out_valid && out_ready) begin
        total++; if (result !== exp_r[got]) $display("FAIL b2b_result[%0d] got %h want %h", got, result, exp_r[got]); else passed++;
        total++; if (flags !== 4'h0) $display("FAIL b2b_flags[%0d] got %h want 0", got, flags); else passed++;
        got++;
      end
      hold_pending = out_valid && !out_ready;
      held = result;
      acc  = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
      cyc++;
    end
    total++; if (got !== 8) $display("FAIL b2b_count got %0d want 8", got); else passed++;
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    total++; if (extra !== 0) $display("FAIL b2b_extra got %0d want 0", extra); else passed++;
  endtask

  task automatic test_reset_midflight();
    int seen;
    logic [31:0] r; logic [3:0] f; int lat;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h40000000; b = 32'h40400000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) $display("FAIL midrst_pre_valid got %b want 1", out_valid); else passed++;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else passed++;
    total++; if (result !== 32'h0) $display("FAIL midrst_result got %h want 00000000", result); else passed++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midrst_ghost got %0d want 0", seen); else passed++;
    run_op(32'h3FC00000, 32'h3FC00000, r, f, lat);
    total++; if (r !== 32'h40100000) $display("FAIL midrst_after got %h want 40100000", r); else passed++;
    total++; if (lat !== 3) $display("FAIL midrst_latency got %0d want 3", lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_rounding();
    test_underflow();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
